timestamp_run_controller: RTL and testbench

Sequences the run input of timestamp_generator for one acquisition at a time.
- Accepts host start/stop commands, with an optional external-trigger arm and a programmable start delay.
- Holds run high for a programmed number of cycles, or until stopped, then enforces a flush gap before re-arming.
- Reports state, stop reason, a run count, and the final timestamp of the last run.

---
 rtl/timestamp_run_controller.sv | 167 ++++++++++++++++
 tb/tb_timestamp_run_controller.sv | 278 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/timestamp_run_controller.sv
// Run sequencer for timestamp_generator: start/stop commands, optional trigger arm,
// start delay, fixed or unlimited run length, and a post-run flush gap.
module timestamp_run_controller #(
  parameter int unsigned DURATION_WIDTH = 32,
  parameter int unsigned DELAY_WIDTH    = 16,
  parameter int unsigned FLUSH_CYCLES   = 4
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      cmd_start,
  input  logic                      cmd_stop,
  input  logic                      cfg_trigger_en,
  input  logic                      ext_trigger,
  input  logic [DELAY_WIDTH-1:0]    cfg_start_delay,
  input  logic [DURATION_WIDTH-1:0] cfg_duration,
  input  logic [63:0]               timestamp,
  output logic                      run,
  output logic                      busy,
  output logic [2:0]                state,
  output logic                      done,
  output logic [1:0]                stop_reason,
  output logic [15:0]               run_counter,
  output logic [63:0]               last_timestamp
);

  localparam int unsigned FLUSH_W = $clog2(FLUSH_CYCLES + 1);
  localparam logic [FLUSH_W-1:0]        FL_ONE     = FLUSH_W'(1);
  localparam logic [FLUSH_W-1:0]        FL_LAST    = FLUSH_W'(FLUSH_CYCLES);
  localparam logic [DELAY_WIDTH-1:0]    DLY_ONE    = DELAY_WIDTH'(1);
  localparam logic [DURATION_WIDTH-1:0] DUR_ONE    = DURATION_WIDTH'(1);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_ARMED = 3'd1,
    S_DELAY = 3'd2,
    S_RUN   = 3'd3,
    S_FLUSH = 3'd4
  } state_t;

  typedef enum logic [1:0] {
    SR_NONE     = 2'd0,
    SR_DURATION = 2'd1,
    SR_HOST     = 2'd2,
    SR_ABORT    = 2'd3
  } reason_t;

  state_t                    st;
  logic                      trig_prev;
  logic [DELAY_WIDTH-1:0]    lat_delay;
  logic [DURATION_WIDTH-1:0] lat_duration;
  logic [DELAY_WIDTH-1:0]    dcnt;
  logic [DURATION_WIDTH-1:0] rcnt;
  logic [FLUSH_W-1:0]        fcnt;

  assign state = st;

  always_ff @(posedge clk) begin
    if (reset) begin
      st             <= S_IDLE;
      run            <= 1'b0;
      busy           <= 1'b0;
      done           <= 1'b0;
      stop_reason    <= SR_NONE;
      run_counter    <= '0;
      last_timestamp <= '0;
      trig_prev      <= 1'b0;
      lat_delay      <= '0;
      lat_duration   <= '0;
      dcnt           <= '0;
      rcnt           <= '0;
      fcnt           <= '0;
    end else begin
      done      <= 1'b0;
      // Tracked in every state so a trigger already high when arming never fires.
      trig_prev <= ext_trigger;
      case (st)
        S_IDLE: begin
          if (cmd_start && !cmd_stop) begin
            lat_delay    <= cfg_start_delay;
            lat_duration <= cfg_duration;
            stop_reason  <= SR_NONE;
            busy         <= 1'b1;
            if (cfg_trigger_en) begin
              st <= S_ARMED;
            end else if (cfg_start_delay != '0) begin
              st   <= S_DELAY;
              dcnt <= DLY_ONE;
            end else begin
              st          <= S_RUN;
              run         <= 1'b1;
              rcnt        <= DUR_ONE;
              run_counter <= run_counter + 16'd1;
            end
          end
        end
        S_ARMED: begin
          if (cmd_stop) begin
            st          <= S_IDLE;
            busy        <= 1'b0;
            done        <= 1'b1;
            stop_reason <= SR_ABORT;
          end else if (ext_trigger && !trig_prev) begin
            if (lat_delay != '0) begin
              st   <= S_DELAY;
              dcnt <= DLY_ONE;
            end else begin
              st          <= S_RUN;
              run         <= 1'b1;
              rcnt        <= DUR_ONE;
              run_counter <= run_counter + 16'd1;
            end
          end
        end
        S_DELAY: begin
          if (cmd_stop) begin
            st          <= S_IDLE;
            busy        <= 1'b0;
            done        <= 1'b1;
            stop_reason <= SR_ABORT;
          end else if (dcnt == lat_delay) begin
            st          <= S_RUN;
            run         <= 1'b1;
            rcnt        <= DUR_ONE;
            run_counter <= run_counter + 16'd1;
          end else begin
            dcnt <= dcnt + DLY_ONE;
          end
        end
        S_RUN: begin
          // Duration completion takes precedence over a coincident host stop.
          if (lat_duration != '0 && rcnt == lat_duration) begin
            st          <= S_FLUSH;
            run         <= 1'b0;
            fcnt        <= FL_ONE;
            stop_reason <= SR_DURATION;
          end else if (cmd_stop) begin
            st          <= S_FLUSH;
            run         <= 1'b0;
            fcnt        <= FL_ONE;
            stop_reason <= SR_HOST;
          end else if (rcnt != '1) begin
            rcnt <= rcnt + DUR_ONE;
          end
        end
        S_FLUSH: begin
          // Generator still holds the final count during the first flush cycle.
          if (fcnt == FL_ONE) begin
            last_timestamp <= timestamp;
          end
          if (fcnt == FL_LAST) begin
            st   <= S_IDLE;
            busy <= 1'b0;
            done <= 1'b1;
          end else begin
            fcnt <= fcnt + FL_ONE;
          end
        end
        default: begin
          st   <= S_IDLE;
          run  <= 1'b0;
          busy <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_timestamp_run_controller.sv
// Bench for timestamp_run_controller: directed vector table, randomized transactions
// against a transaction-level expectation model, plus reset and idle corner sequences.
module tb_timestamp_run_controller;

  localparam int unsigned FLUSH = 4;

  logic        clk;
  logic        reset;
  logic        cmd_start;
  logic        cmd_stop;
  logic        cfg_trigger_en;
  logic        ext_trigger;
  logic [15:0] cfg_start_delay;
  logic [31:0] cfg_duration;
  logic [63:0] ts;
  logic        run;
  logic        busy;
  logic [2:0]  state;
  logic        done;
  logic [1:0]  stop_reason;
  logic [15:0] run_counter;
  logic [63:0] last_timestamp;

  timestamp_run_controller #(
    .DURATION_WIDTH(32),
    .DELAY_WIDTH(16),
    .FLUSH_CYCLES(FLUSH)
  ) dut (
    .clk(clk),
    .reset(reset),
    .cmd_start(cmd_start),
    .cmd_stop(cmd_stop),
    .cfg_trigger_en(cfg_trigger_en),
    .ext_trigger(ext_trigger),
    .cfg_start_delay(cfg_start_delay),
    .cfg_duration(cfg_duration),
    .timestamp(ts),
    .run(run),
    .busy(busy),
    .state(state),
    .done(done),
    .stop_reason(stop_reason),
    .run_counter(run_counter),
    .last_timestamp(last_timestamp)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // timestamp_generator stand-in
  always @(posedge clk) begin
    if (reset || !run) ts <= '0;
    else               ts <= ts + 64'd1;
  end

  typedef struct {
    bit          trig;
    bit          pre_high;
    int unsigned delay;
    int unsigned dur;
    int unsigned stop_run;
    int unsigned abort_at;
    int unsigned exp_run;
    int unsigned exp_reason;
  } vec_t;

  int          tests = 0;
  int          fails = 0;
  int unsigned model_cnt = 0;
  longint unsigned model_last = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic vec_t gen_rand();
    vec_t v;
    v.trig     = bit'($urandom_range(0, 1));
    v.pre_high = bit'($urandom_range(0, 1));
    v.delay    = $urandom_range(0, 6);
    v.dur      = $urandom_range(0, 40);
    if (v.dur == 0) v.stop_run = $urandom_range(1, 40);
    else v.stop_run = ($urandom_range(0, 1) == 1) ? $urandom_range(1, 45) : 0;
    v.abort_at = 0;
    if ($urandom_range(0, 4) == 0) begin
      if (v.trig) v.abort_at = $urandom_range(1, 2);
      else if (v.delay >= 2) v.abort_at = $urandom_range(1, v.delay - 1);
    end
    if (v.abort_at != 0) begin
      v.exp_run = 0; v.exp_reason = 3;
    end else if (v.dur != 0 && (v.stop_run == 0 || v.stop_run >= v.dur)) begin
      v.exp_run = v.dur; v.exp_reason = 1;
    end else begin
      v.exp_run = v.stop_run; v.exp_reason = 2;
    end
    return v;
  endfunction

  task automatic do_txn(input vec_t v);
    int          cyc;
    int          first_run;
    int          trig_cyc;
    int unsigned runhi;
    int unsigned flush;
    int unsigned dones;
    bit          finished;
    bit          stopped;
    bit          inv_ok;
    bit          abort;
    logic [63:0] seq;
    logic [63:0] exp_seq;
    logic [2:0]  last_st;
    first_run = -1; trig_cyc = 0; runhi = 0; flush = 0; dones = 0;
    finished = 0; stopped = 0; inv_ok = 1; abort = (v.abort_at != 0);

    @(negedge clk);
    cfg_trigger_en  = v.trig;
    cfg_start_delay = 16'(v.delay);
    cfg_duration    = v.dur;
    ext_trigger     = v.trig && v.pre_high;
    cmd_start       = 1'b1;
    @(negedge clk);
    cmd_start = 1'b0;
    cyc = 1;
    seq = {61'd0, state};
    last_st = state;
    while (!finished && cyc < 3000) begin
      if (state != last_st) begin
        seq = (seq << 3) | {61'd0, state};
        last_st = state;
      end
      if ((run !== (state == 3'd3)) || (busy !== (state != 3'd0))) inv_ok = 0;
      cmd_start = 1'b0;
      cmd_stop  = 1'b0;
      if (run === 1'b1) begin
        runhi++;
        if (first_run < 0) first_run = cyc;
      end
      if (state == 3'd4) flush++;
      if (done === 1'b1) begin
        dones++;
        finished = 1;
      end
      if (!finished) begin
        if (v.trig) begin
          if (v.pre_high) begin
            if (cyc == 3) ext_trigger = 1'b0;
            if (cyc == 5 && !abort) begin ext_trigger = 1'b1; trig_cyc = 5; end
          end else if (cyc == 4 && !abort) begin
            ext_trigger = 1'b1; trig_cyc = 4;
          end
        end
        if (abort && cyc == int'(v.abort_at)) cmd_stop = 1'b1;
        if (!stopped && v.stop_run != 0 && runhi == v.stop_run && run === 1'b1) begin
          cmd_stop = 1'b1;
          stopped  = 1;
        end
        if (runhi == 2 && run === 1'b1) begin
          cmd_start       = 1'b1;
          cfg_duration    = $urandom_range(1, 3);
          cfg_start_delay = 16'($urandom_range(1, 3));
          cfg_trigger_en  = 1'b0;
        end
        if (state == 3'd4 && flush == 1) cmd_start = 1'b1;
        if (state == 3'd4 && flush == 2) cmd_stop = 1'b1;
        @(negedge clk);
        cyc++;
      end
    end
    cmd_start = 1'b0;
    cmd_stop  = 1'b0;

    exp_seq = '0;
    if (v.trig) exp_seq = (exp_seq << 3) | 64'd1;
    if (!(abort && v.trig) && v.delay > 0) exp_seq = (exp_seq << 3) | 64'd2;
    if (!abort) begin
      exp_seq = (exp_seq << 3) | 64'd3;
      exp_seq = (exp_seq << 3) | 64'd4;
    end
    exp_seq = exp_seq << 3;

    check("timeout", 64'(finished), 64'd1);
    check("run_cycles", 64'(runhi), 64'(v.exp_run));
    check("flush_cycles", 64'(flush), abort ? 64'd0 : 64'(FLUSH));
    if (!abort) check("start_latency", 64'(first_run - trig_cyc), 64'(v.delay + 1));
    check("state_seq", seq, exp_seq);
    check("invariants", 64'(inv_ok), 64'd1);
    if (!abort) begin
      model_cnt  = (model_cnt + 1) & 32'hFFFF;
      model_last = v.exp_run;
    end
    check("stop_reason", 64'(stop_reason), 64'(v.exp_reason));
    check("run_counter", 64'(run_counter), 64'(model_cnt));
    check("last_timestamp", last_timestamp, model_last);
    @(negedge clk);
    ext_trigger = 1'b0;
    if (done === 1'b1) dones++;
    check("done_pulses", 64'(dones), 64'd1);
  endtask

  vec_t tbl[11];

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    //            trig pre dly dur stop abort exp_run reason
    tbl[0]  = '{0, 0, 0, 50,  0, 0, 50, 1};
    tbl[1]  = '{0, 0, 5, 10,  0, 0, 10, 1};
    tbl[2]  = '{0, 0, 0,  0, 30, 0, 30, 2};
    tbl[3]  = '{0, 0, 0,  0, 30, 0, 30, 2};
    tbl[4]  = '{1, 1, 0, 20,  0, 0, 20, 1};
    tbl[5]  = '{1, 0, 0,  5,  0, 2,  0, 3};
    tbl[6]  = '{0, 0, 6,  5,  0, 3,  0, 3};
    tbl[7]  = '{0, 0, 0, 15, 15, 0, 15, 1};
    tbl[8]  = '{0, 0, 0,  1,  0, 0,  1, 1};
    tbl[9]  = '{0, 0, 1,  3,  1, 0,  1, 2};
    tbl[10] = '{1, 0, 3,  7,  0, 0,  7, 1};

    reset = 1'b1; cmd_start = 1'b0; cmd_stop = 1'b0; cfg_trigger_en = 1'b0;
    ext_trigger = 1'b0; cfg_start_delay = '0; cfg_duration = '0;
    repeat (3) @(negedge clk);
    check("rst_run", 64'(run), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_done", 64'(done), 64'd0);
    check("rst_state", 64'(state), 64'd0);
    check("rst_reason", 64'(stop_reason), 64'd0);
    check("rst_counter", 64'(run_counter), 64'd0);
    check("rst_last_ts", last_timestamp, 64'd0);
    reset = 1'b0;

    for (int i = 0; i < 11; i++) do_txn(tbl[i]);
    for (int i = 0; i < 25; i++) do_txn(gen_rand());

    // start and stop together in IDLE: stop wins, nothing starts
    @(negedge clk);
    cfg_trigger_en = 1'b0; cfg_start_delay = '0; cfg_duration = 32'd5;
    cmd_start = 1'b1; cmd_stop = 1'b1;
    @(negedge clk);
    cmd_start = 1'b0; cmd_stop = 1'b0;
    check("startstop_state", 64'(state), 64'd0);
    check("startstop_busy", 64'(busy), 64'd0);
    repeat (3) @(negedge clk);
    check("startstop_run", 64'(run), 64'd0);
    check("startstop_counter", 64'(run_counter), 64'(model_cnt));

    // reset in the middle of an unlimited run
    cfg_duration = '0;
    cmd_start = 1'b1;
    @(negedge clk);
    cmd_start = 1'b0;
    repeat (10) @(negedge clk);
    check("pre_reset_run", 64'(run), 64'd1);
    reset = 1'b1;
    @(negedge clk);
    check("midrst_run", 64'(run), 64'd0);
    check("midrst_state", 64'(state), 64'd0);
    check("midrst_busy", 64'(busy), 64'd0);
    check("midrst_counter", 64'(run_counter), 64'd0);
    check("midrst_last_ts", last_timestamp, 64'd0);
    check("midrst_reason", 64'(stop_reason), 64'd0);
    reset = 1'b0;
    model_cnt = 0;
    model_last = 0;
    do_txn('{0, 0, 2, 8, 0, 0, 8, 1});

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
